// File: rtl/qos_tx_sched.sv
// Transmit-side QoS scheduler: four per-class FIFOs drained by a weighted round-robin
// arbiter into one registered push/data stream, with per-class sent counters readable via req/idx.
module qos_tx_sched #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [3:0]        push_in,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    input  logic [3:0]        umbral_h,
    input  logic [15:0]       weight,
    input  logic              ds_almost_full,
    output logic              push_out,
    output logic [DATA_W-1:0] data_out,
    output logic [3:0]        full_o,
    output logic [3:0]        almost_full_o,
    output logic [3:0]        ovf_o,
    output logic              idle_out,
    input  logic              req,
    input  logic [2:0]        idx,
    output logic              valid,
    output logic [4:0]        data
);
    localparam int unsigned NCLS  = 4;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CTR_W = 5;
    localparam int unsigned WGT_W = 4;

    logic [DATA_W-1:0] r_mem     [NCLS][DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr  [NCLS];
    logic [PTR_W-1:0]  r_rd_ptr  [NCLS];
    logic [CNT_W-1:0]  r_fill    [NCLS];
    logic [CTR_W-1:0]  r_cls_cnt [NCLS];
    logic [CTR_W-1:0]  r_tot_cnt;
    logic [1:0]        r_cur;
    logic [WGT_W-1:0]  r_cred;

    logic [DATA_W-1:0] w_din      [NCLS];
    logic [CNT_W-1:0]  w_fill_nxt [NCLS];
    logic [NCLS-1:0]   w_nonempty;
    logic [NCLS-1:0]   w_is_full;
    logic [NCLS-1:0]   w_wr_ok;
    logic [NCLS-1:0]   w_pop;
    logic              w_grant;
    logic [1:0]        w_g;
    logic [1:0]        w_cand;
    logic              w_found;
    logic [WGT_W-1:0]  w_wgt;
    logic [WGT_W-1:0]  w_reload;
    logic              w_idle_nxt;
    logic [CTR_W-1:0]  w_rd_val;

    assign w_din[0] = data_in0;
    assign w_din[1] = data_in1;
    assign w_din[2] = data_in2;
    assign w_din[3] = data_in3;

    assign w_grant = enable & ~ds_almost_full & (|w_nonempty);

    // FIFO status from registered fill levels; a full FIFO refuses writes even if popped this cycle
    always_comb begin
        for (int i = 0; i < int'(NCLS); i++) begin
            w_nonempty[i] = (r_fill[i] != '0);
            w_is_full[i]  = (r_fill[i] == CNT_W'(DEPTH));
            w_wr_ok[i]    = push_in[i] & ~w_is_full[i];
        end
    end

    // WRR selection: stay on cur while it has credit, else scan cur+1 .. cur
    always_comb begin
        w_g     = r_cur;
        w_cand  = r_cur;
        w_found = 1'b0;
        if (!(w_nonempty[r_cur] && (r_cred != '0))) begin
            for (int k = 1; k <= 4; k++) begin
                w_cand = 2'(r_cur + 2'(k));
                if (!w_found && w_nonempty[w_cand]) begin
                    w_g     = w_cand;
                    w_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_wgt      = weight[{w_g, 2'b00} +: WGT_W];
        w_reload   = (w_wgt == '0) ? '0 : WGT_W'(w_wgt - WGT_W'(1));
        w_idle_nxt = ~w_grant;
        for (int i = 0; i < int'(NCLS); i++) begin
            w_pop[i]      = w_grant && (w_g == 2'(i));
            w_fill_nxt[i] = CNT_W'(r_fill[i] + CNT_W'(w_wr_ok[i]) - CNT_W'(w_pop[i]));
            if (w_fill_nxt[i] != '0) w_idle_nxt = 1'b0;
        end
    end

    always_comb begin
        case (idx)
            3'd0, 3'd1, 3'd2, 3'd3: w_rd_val = r_cls_cnt[idx[1:0]];
            3'd4:                   w_rd_val = r_tot_cnt;
            default:                w_rd_val = '0;
        endcase
    end

    // Storage array carries no reset; validity is tracked by the pointers and fill levels
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NCLS); i++) begin
            if (w_wr_ok[i]) r_mem[i][r_wr_ptr[i]] <= w_din[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NCLS); i++) begin
                r_wr_ptr[i]  <= '0;
                r_rd_ptr[i]  <= '0;
                r_fill[i]    <= '0;
                r_cls_cnt[i] <= '0;
            end
            r_tot_cnt     <= '0;
            r_cur         <= 2'd3;
            r_cred        <= '0;
            push_out      <= 1'b0;
            data_out      <= '0;
            full_o        <= '0;
            almost_full_o <= '0;
            ovf_o         <= '0;
            idle_out      <= 1'b1;
            valid         <= 1'b0;
            data          <= '0;
        end else begin
            for (int i = 0; i < int'(NCLS); i++) begin
                if (w_wr_ok[i]) r_wr_ptr[i] <= PTR_W'(r_wr_ptr[i] + PTR_W'(1));
                if (w_pop[i])   r_rd_ptr[i] <= PTR_W'(r_rd_ptr[i] + PTR_W'(1));
                r_fill[i]        <= w_fill_nxt[i];
                full_o[i]        <= (w_fill_nxt[i] == CNT_W'(DEPTH));
                almost_full_o[i] <= (32'(w_fill_nxt[i]) >= 32'(umbral_h));
            end
            ovf_o    <= ovf_o | (push_in & w_is_full);
            idle_out <= w_idle_nxt;
            if (w_grant) begin
                push_out       <= 1'b1;
                data_out       <= r_mem[w_g][r_rd_ptr[w_g]];
                r_cls_cnt[w_g] <= CTR_W'(r_cls_cnt[w_g] + CTR_W'(1));
                r_tot_cnt      <= CTR_W'(r_tot_cnt + CTR_W'(1));
                if (w_g == r_cur) begin
                    // fallback re-grant of cur with no credit left keeps credit at zero
                    r_cred <= (r_cred != '0) ? WGT_W'(r_cred - WGT_W'(1)) : '0;
                end else begin
                    r_cur  <= w_g;
                    r_cred <= w_reload;
                end
            end else begin
                push_out <= 1'b0;
            end
            valid <= req;
            if (req) data <= w_rd_val;
        end
    end
endmodule

// File: tb/tb_qos_tx_sched.sv
// Directed self-checking bench for qos_tx_sched: latency, WRR order, back-pressure,
// overflow, counter reads and asynchronous reset.
module tb_qos_tx_sched;
    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  push_in;
    logic [11:0] data_in0, data_in1, data_in2, data_in3;
    logic [3:0]  umbral_h;
    logic [15:0] weight;
    logic        ds_almost_full;
    logic        push_out;
    logic [11:0] data_out;
    logic [3:0]  full_o, almost_full_o, ovf_o;
    logic        idle_out;
    logic        req;
    logic [2:0]  idx;
    logic        valid;
    logic [4:0]  data;

    int n_chk  = 0;
    int n_fail = 0;

    qos_tx_sched #(.DATA_W(12), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .push_in(push_in),
        .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
        .umbral_h(umbral_h), .weight(weight), .ds_almost_full(ds_almost_full),
        .push_out(push_out), .data_out(data_out), .full_o(full_o),
        .almost_full_o(almost_full_o), .ovf_o(ovf_o), .idle_out(idle_out),
        .req(req), .idx(idx), .valid(valid), .data(data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog_timeout simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; push_in = '0; ds_almost_full = 1'b0;
        data_in0 = '0; data_in1 = '0; data_in2 = '0; data_in3 = '0;
        umbral_h = 4'd3; weight = 16'h1111; req = 1'b0; idx = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; push_in = '0; ds_almost_full = 1'b0;
        data_in0 = '0; data_in1 = '0; data_in2 = '0; data_in3 = '0;
        umbral_h = 4'd3; weight = 16'h1111; req = 1'b0; idx = '0;
        tick();
        n_chk++;
        if ({push_out, data_out, full_o, almost_full_o, ovf_o, valid, data} !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got push=%b data_out=%h full=%b af=%b ovf=%b valid=%b data=%0d exp all zero",
                     push_out, data_out, full_o, almost_full_o, ovf_o, valid, data);
        end
        n_chk++;
        if (idle_out !== 1'b1) begin
            n_fail++; $display("FAIL reset_idle got %b exp 1", idle_out);
        end
        reset = 1'b0;
    endtask

    // Test 1: single class, 2-cycle latency, in-order, idle afterwards
    task automatic test_single_class();
        do_reset();
        enable = 1'b1;
        push_in = 4'b0100; data_in2 = 12'hA01;
        tick();
        n_chk++;
        if (push_out !== 1'b0) begin n_fail++; $display("FAIL t1_no_bypass got %b exp 0", push_out); end
        data_in2 = 12'hB02;
        tick();
        n_chk++;
        if (push_out !== 1'b1 || data_out !== 12'hA01) begin
            n_fail++; $display("FAIL t1_word_a got push=%b data=%h exp 1/a01", push_out, data_out);
        end
        data_in2 = 12'hC03;
        tick();
        n_chk++;
        if (push_out !== 1'b1 || data_out !== 12'hB02) begin
            n_fail++; $display("FAIL t1_word_b got push=%b data=%h exp 1/b02", push_out, data_out);
        end
        push_in = '0;
        tick();
        n_chk++;
        if (push_out !== 1'b1 || data_out !== 12'hC03 || idle_out !== 1'b0) begin
            n_fail++; $display("FAIL t1_word_c got push=%b data=%h idle=%b exp 1/c03/0", push_out, data_out, idle_out);
        end
        tick();
        n_chk++;
        if (push_out !== 1'b0 || data_out !== 12'hC03 || idle_out !== 1'b1) begin
            n_fail++; $display("FAIL t1_drained got push=%b data=%h idle=%b exp 0/c03/1", push_out, data_out, idle_out);
        end
    endtask

    // Test 2: w0=2, w1=1 -> order 0,0,1,0,0,1,1,1
    task automatic test_wrr();
        logic [11:0] exp_d [8];
        exp_d = '{12'h010, 12'h011, 12'h020, 12'h012, 12'h013, 12'h021, 12'h022, 12'h023};
        do_reset();
        weight = 16'h1112;
        for (int k = 0; k < 4; k++) begin
            push_in = 4'b0011; data_in0 = 12'(12'h010 + k); data_in1 = 12'(12'h020 + k);
            tick();
        end
        push_in = '0;
        n_chk++;
        if (full_o !== 4'b0011 || almost_full_o !== 4'b0011 || push_out !== 1'b0) begin
            n_fail++; $display("FAIL t2_loaded got full=%b af=%b push=%b exp 0011/0011/0", full_o, almost_full_o, push_out);
        end
        enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_chk++;
            if (push_out !== 1'b1 || data_out !== exp_d[k]) begin
                n_fail++; $display("FAIL t2_order[%0d] got push=%b data=%h exp 1/%h", k, push_out, data_out, exp_d[k]);
            end
        end
        tick();
        n_chk++;
        if (push_out !== 1'b0 || idle_out !== 1'b1) begin
            n_fail++; $display("FAIL t2_end got push=%b idle=%b exp 0/1", push_out, idle_out);
        end
    endtask

    // Test 5: counter reads following test 2, then 40 more words on class 1
    task automatic test_counter_read();
        logic [2:0] rd_idx [5];
        logic [4:0] rd_exp [5];
        rd_idx = '{3'd0, 3'd1, 3'd4, 3'd6, 3'd3};
        rd_exp = '{5'd4, 5'd4, 5'd8, 5'd0, 5'd0};
        for (int k = 0; k < 5; k++) begin
            req = 1'b1; idx = rd_idx[k];
            tick();
            n_chk++;
            if (valid !== 1'b1 || data !== rd_exp[k]) begin
                n_fail++; $display("FAIL t5_read_idx%0d got valid=%b data=%0d exp 1/%0d", rd_idx[k], valid, data, rd_exp[k]);
            end
        end
        req = 1'b0; idx = 3'd4;
        tick();
        n_chk++;
        if (valid !== 1'b0 || data !== 5'd0) begin
            n_fail++; $display("FAIL t5_no_req got valid=%b data=%0d exp 0/0", valid, data);
        end
        enable = 1'b1;
        for (int k = 0; k < 40; k++) begin
            push_in = 4'b0010; data_in1 = 12'(k);
            tick();
        end
        push_in = '0;
        repeat (4) tick();
        n_chk++;
        if (ovf_o !== 4'b0000 || idle_out !== 1'b1) begin
            n_fail++; $display("FAIL t5_stream_clean got ovf=%b idle=%b exp 0000/1", ovf_o, idle_out);
        end
        req = 1'b1; idx = 3'd1;
        tick();
        n_chk++;
        if (valid !== 1'b1 || data !== 5'd12) begin
            n_fail++; $display("FAIL t5_wrap_cls1 got valid=%b data=%0d exp 1/12", valid, data);
        end
        idx = 3'd4;
        tick();
        n_chk++;
        if (data !== 5'd16) begin
            n_fail++; $display("FAIL t5_wrap_total got %0d exp 16", data);
        end
        req = 1'b0;
    endtask

    // Test 3: ds_almost_full for 3 cycles -> 3-cycle gap shifted by 1, no loss/dup
    task automatic test_back_pressure();
        logic [11:0] exp_d [8];
        logic [11:0] got_d [$];
        logic        exp_p;
        exp_d = '{12'h100, 12'h200, 12'h101, 12'h201, 12'h102, 12'h202, 12'h103, 12'h203};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push_in = 4'b0011; data_in0 = 12'(12'h100 + k); data_in1 = 12'(12'h200 + k);
            tick();
        end
        push_in = '0;
        enable = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            exp_p = (c <= 11) && !(c >= 3 && c <= 5);
            n_chk++;
            if (push_out !== exp_p) begin
                n_fail++; $display("FAIL t3_push_cycle%0d got %b exp %b", c, push_out, exp_p);
            end
            if (push_out === 1'b1) got_d.push_back(data_out);
            ds_almost_full = (c >= 2 && c <= 4);
        end
        n_chk++;
        if (got_d.size() != 8) begin
            n_fail++; $display("FAIL t3_word_count got %0d exp 8", got_d.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_chk++;
                if (got_d[k] !== exp_d[k]) begin
                    n_fail++; $display("FAIL t3_word[%0d] got %h exp %h", k, got_d[k], exp_d[k]);
                end
            end
        end
    endtask

    // Test 4: five pushes into class 3 with arbiter disabled
    task automatic test_overflow();
        int n_out;
        logic [11:0] exp_w;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            push_in = 4'b1000; data_in3 = 12'(12'h300 + k);
            tick();
            if (k == 3) begin
                n_chk++;
                if (full_o !== 4'b1000 || ovf_o !== 4'b0000) begin
                    n_fail++; $display("FAIL t4_full_after4 got full=%b ovf=%b exp 1000/0000", full_o, ovf_o);
                end
            end
        end
        push_in = '0;
        n_chk++;
        if (ovf_o !== 4'b1000 || full_o !== 4'b1000) begin
            n_fail++; $display("FAIL t4_ovf_after5 got ovf=%b full=%b exp 1000/1000", ovf_o, full_o);
        end
        enable = 1'b1;
        n_out = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (push_out === 1'b1) begin
                exp_w = 12'(12'h300 + n_out);
                n_chk++;
                if (data_out !== exp_w) begin
                    n_fail++; $display("FAIL t4_word[%0d] got %h exp %h", n_out, data_out, exp_w);
                end
                n_out++;
            end
        end
        n_chk++;
        if (n_out != 4 || ovf_o !== 4'b1000 || full_o !== 4'b0000) begin
            n_fail++; $display("FAIL t4_drain got words=%0d ovf=%b full=%b exp 4/1000/0000", n_out, ovf_o, full_o);
        end
    endtask

    // Test 6: asynchronous reset between edges, then first grant goes to class 0
    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            push_in = 4'b0001; data_in0 = 12'(12'h0F0 + k);
            tick();
        end
        push_in = '0;
        enable = 1'b1;
        tick();
        n_chk++;
        if (push_out !== 1'b1 || ovf_o !== 4'b0001) begin
            n_fail++; $display("FAIL t6_pre got push=%b ovf=%b exp 1/0001", push_out, ovf_o);
        end
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if (push_out !== 1'b0 || data_out !== 12'h000 || full_o !== 4'b0000 || ovf_o !== 4'b0000 || idle_out !== 1'b1) begin
            n_fail++; $display("FAIL t6_async got push=%b data=%h full=%b ovf=%b idle=%b exp 0/000/0000/0000/1",
                               push_out, data_out, full_o, ovf_o, idle_out);
        end
        #2 reset = 1'b0;
        push_in = 4'b1001; data_in0 = 12'h0A0; data_in3 = 12'h3A0;
        tick();
        push_in = '0;
        tick();
        n_chk++;
        if (push_out !== 1'b1 || data_out !== 12'h0A0) begin
            n_fail++; $display("FAIL t6_first_grant got push=%b data=%h exp 1/0a0", push_out, data_out);
        end
        tick();
        n_chk++;
        if (push_out !== 1'b1 || data_out !== 12'h3A0) begin
            n_fail++; $display("FAIL t6_second_grant got push=%b data=%h exp 1/3a0", push_out, data_out);
        end
        tick();
        n_chk++;
        if (push_out !== 1'b0 || idle_out !== 1'b1) begin
            n_fail++; $display("FAIL t6_discarded got push=%b idle=%b exp 0/1", push_out, idle_out);
        end
    endtask

    initial begin
        test_reset();
        test_single_class();
        test_wrr();
        test_counter_read();
        test_back_pressure();
        test_overflow();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
